// File: rtl/mdu.sv
// Iterative multiply/divide unit owning HI/LO: shift-add multiply and restoring divide,
// one bit per cycle, then a sign-fixup cycle that commits the result.
module mdu (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  // state | meaning
  // IDLE  | accepting start; MTHI/MTLO write directly
  // MUL   | one shift-add step per cycle
  // DIV   | one restoring step per cycle
  // FIX   | apply signs, commit HI/LO, pulse done
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;
  logic [31:0] a_q, a_d;
  logic        neg_q, neg_d;
  logic        neg_rem_q, neg_rem_d;
  logic        is_div_q, is_div_d;
  logic        dz_q, dz_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic        sgn, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_shift, div_diff;
  logic [63:0] div_next;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  assign sgn   = ~op[0];
  assign a_neg = sgn & a[31];
  assign b_neg = sgn & b[31];
  assign a_mag = a_neg ? (32'd0 - a) : a;
  assign b_mag = b_neg ? (32'd0 - b) : b;

  // acc holds {partial product, remaining multiplier bits} during MUL
  assign mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opnd_q : 32'd0)};
  assign mul_next = {mul_sum, acc_q[31:1]};

  // acc holds {partial remainder, dividend bits becoming quotient bits} during DIV
  assign div_shift = {acc_q[63:32], acc_q[31]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_next  = div_diff[32] ? {div_shift[31:0], acc_q[30:0], 1'b0}
                                  : {div_diff[31:0], acc_q[30:0], 1'b1};

  assign prod_fix = neg_q ? (64'd0 - acc_q) : acc_q;
  assign quo_fix  = neg_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
  assign rem_fix  = neg_rem_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    a_d       = a_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    is_div_d  = is_div_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op == 3'b100) begin
            hi_d = a;
          end else if (op == 3'b101) begin
            lo_d = a;
          end else if (op[2] == 1'b0) begin
            a_d       = a;
            neg_d     = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            is_div_d  = op[1];
            dz_d      = op[1] & (b == 32'd0);
            cnt_d     = 5'd0;
            if (op[1]) begin
              acc_d   = {32'd0, a_mag};
              opnd_d  = b_mag;
              state_d = S_DIV;
            end else begin
              acc_d   = {32'd0, b_mag};
              opnd_d  = a_mag;
              state_d = S_MUL;
            end
          end
        end
      end
      S_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIX;
      end
      S_DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIX;
      end
      default: begin
        if (!is_div_q) begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end else if (dz_q) begin
          hi_d = a_q;
          lo_d = 32'hFFFF_FFFF;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      acc_q     <= 64'd0;
      opnd_q    <= 32'd0;
      a_q       <= 32'd0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      is_div_q  <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      a_q       <= a_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      is_div_q  <= is_div_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != S_IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: expected HI/LO and completion cycle are queued at issue,
// and a monitor pops and compares on every done pulse.
module tb_mdu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0, b = 32'd0;
  logic [31:0] hi, lo;
  logic        busy, done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  mdu dut (.clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
           .hi(hi), .lo(lo), .busy(busy), .done(done));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural result from plain arithmetic; returns {hi, lo}.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    longint sa, sy, q, r;
    p = 64'd0;
    case (o)
      3'd0: begin sa = $signed(x); sy = $signed(y); p = sa * sy; end
      3'd1: p = {32'd0, x} * {32'd0, y};
      default: begin
        if (y == 32'd0) p = {x, 32'hFFFF_FFFF};
        else if (o == 3'd2) begin
          sa = $signed(x); sy = $signed(y);
          q = sa / sy; r = sa % sy;
          p = {r[31:0], q[31:0]};
        end else p = {x % y, x / y};
      end
    endcase
    return p;
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_done: got done=1 expected no pending result (cyc %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result_hi", {32'd0, hi}, {32'd0, e.hi});
        check("result_lo", {32'd0, lo}, {32'd0, e.lo});
        check("result_latency", 64'(cyc), 64'(e.cyc));
        check("busy_at_done", {63'd0, busy}, 64'd0);
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input bit wait_idle);
    int t;
    bit acc;
    logic [31:0] pre_hi, pre_lo;
    exp_t e;
    t = 0;
    @(negedge clk);
    if (wait_idle) begin
      while (busy && t < 200) begin @(negedge clk); t++; end
      if (t >= 200) begin checks++; failures++; $display("FAIL idle_timeout: busy still 1 after 200 cycles"); end
    end
    acc = !busy;
    pre_hi = hi; pre_lo = lo;
    op = o; a = x; b = y; start = 1'b1;
    if (acc && o < 3'd4) begin
      {e.hi, e.lo} = model(o, x, y);
      e.cyc = cyc + 34;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
    if (!acc) check("ignored_keeps_busy", {63'd0, busy}, 64'd1);
    else if (o == 3'd4) begin
      check("mthi", {hi, lo}, {x, pre_lo});
      check("mt_no_busy_done", {62'd0, busy, done}, 64'd0);
    end else if (o == 3'd5) begin
      check("mtlo", {hi, lo}, {pre_hi, x});
      check("mt_no_busy_done", {62'd0, busy, done}, 64'd0);
    end else if (o >= 3'd6) begin
      check("nop_ignored", {hi, lo, 31'd0, busy}, {pre_hi, pre_lo, 32'd0});
    end else check("busy_after_accept", {63'd0, busy}, 64'd1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin @(negedge clk); t++; end
    if (sb.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout: %0d results pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    bit saw_one;
    int t;
    logic [31:0] corners [6];
    corners[0] = 32'd0; corners[1] = 32'hFFFF_FFFF; corners[2] = 32'h8000_0000;
    corners[3] = 32'd1; corners[4] = 32'h7FFF_FFFF; corners[5] = 32'd7;

    repeat (3) @(negedge clk);
    check("reset_state", {hi, lo}, 64'd0);
    check("reset_busy_done", {62'd0, busy, done}, 64'd0);
    rst = 1'b0;

    issue(3'd0, 32'hFFFF_FFFD, 32'd7, 1);
    issue(3'd1, 32'hFFFF_FFFD, 32'd7, 1);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1);
    issue(3'd3, 32'd100, 32'd7, 1);
    issue(3'd3, 32'h0000_1234, 32'd0, 1);
    issue(3'd2, 32'h0000_1234, 32'd0, 1);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    drain();

    issue(3'd4, 32'hDEAD_BEEF, 32'd0, 1);
    issue(3'd5, 32'h0BAD_F00D, 32'd0, 0);
    issue(3'd6, 32'h1111_1111, 32'd2, 1);

    // Starts while busy must be dropped, including MTHI
    issue(3'd1, 32'd5, 32'd6, 1);
    repeat (8) @(negedge clk);
    issue(3'd4, 32'd1, 32'd0, 0);
    issue(3'd3, 32'd50, 32'd5, 0);
    saw_one = 1'b0; t = 0;
    while (sb.size() != 0 && t < 60) begin
      @(negedge clk); t++;
      if (hi == 32'd1) saw_one = 1'b1;
    end
    check("hi_never_one", {63'd0, saw_one}, 64'd0);
    drain();

    // Reset mid-divide aborts without a done pulse
    issue(3'd2, 32'd1000, 32'd3, 1);
    repeat (13) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_reset_hilo", {hi, lo}, 64'd0);
    check("abort_reset_busy_done", {62'd0, busy, done}, 64'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    issue(3'd0, 32'd3, 32'd4, 1);
    drain();

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 2) == 0) rb = rb & 32'h0000_00FF;
      issue(ro, ra, rb, 1);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
